// File: rtl/pe_tile_pkg.sv
// pe_tile_pkg
// Shared definitions for the parametrised CGRA routing tile (pe_tile_param).
// Contents:
//   - configuration block codes carried in config_addr[31:16]
//   - PE operation encoding (config_data[2:0] of a CLB write)
//   - switch-box selector encoding (2 bits per output track)
//   - sbWords(): number of 32-bit switch-box config words for a track count
package pe_tile_pkg;

  localparam logic [15:0] CLB_CODE     = 16'd4;
  localparam logic [15:0] CB1_CODE     = 16'd5;
  localparam logic [15:0] CB0_CODE     = 16'd6;
  localparam logic [15:0] SB_BASE_CODE = 16'd7;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_PASS = 3'd5,
    OP_NOT  = 3'd6,
    OP_ACC  = 3'd7
  } peOp_t;

  // Source choice for one switch-box output, relative to the output side s.
  typedef enum logic [1:0] {
    SB_OPPOSITE = 2'd0,
    SB_NEXT     = 2'd1,
    SB_PREV     = 2'd2,
    SB_PE       = 2'd3
  } sbSel_t;

  // Two selector bits per output track, four sides, packed into 32-bit words.
  function automatic int sbWords(input int tracks);
    return (8 * tracks + 31) / 32;
  endfunction

endpackage

// File: rtl/pe_tile_clb.sv
// pe_tile_clb
// Processing element of the routing tile: holds the CLB configuration
// ({REG, OP}), the PE output register and the ALU.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_cfgWrite       a CLB configuration write lands on this edge
//   i_cfgData[3:0]   {REG, OP[2:0]} of the write
//   i_op0, i_op1     operands from the two connect boxes
//   o_result         PE result as seen by the switch box
//   o_peReg          registered PE value (always the register, never the ALU)
//   o_cfg[3:0]       stored {REG, OP} for readback
module pe_tile_clb
  import pe_tile_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cfgWrite,
  input  logic [3:0]       i_cfgData,
  input  logic [WIDTH-1:0] i_op0,
  input  logic [WIDTH-1:0] i_op1,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_peReg,
  output logic [3:0]       o_cfg
);

  peOp_t            r_op;
  logic             r_regOut;
  logic [WIDTH-1:0] r_peReg;
  logic [WIDTH-1:0] w_alu;

  // ALU. For ACC the "result" is the next accumulator value, so the same
  // signal serves as both the live result and the register's next state.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_AND:  w_alu = i_op0 & i_op1;
      OP_OR:   w_alu = i_op0 | i_op1;
      OP_XOR:  w_alu = i_op0 ^ i_op1;
      OP_ADD:  w_alu = i_op0 + i_op1;
      OP_SUB:  w_alu = i_op0 - i_op1;
      OP_PASS: w_alu = i_op0;
      OP_NOT:  w_alu = ~i_op0;
      OP_ACC:  w_alu = r_peReg + i_op0;
      default: w_alu = '0;
    endcase
  end

  // Config and PE register. A CLB write restarts the register from zero on
  // the same edge, so a fresh ACC always starts counting from 0 and a new
  // registered op never exposes a stale value from the previous op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= OP_AND;
      r_regOut <= 1'b0;
      r_peReg  <= '0;
    end else if (i_cfgWrite) begin
      r_op     <= peOp_t'(i_cfgData[2:0]);
      r_regOut <= i_cfgData[3];
      r_peReg  <= '0;
    end else begin
      r_peReg  <= w_alu;
    end
  end

  // ACC is inherently registered regardless of the REG bit.
  assign o_result = (r_regOut || (r_op == OP_ACC)) ? r_peReg : w_alu;
  assign o_peReg  = r_peReg;
  assign o_cfg    = {r_regOut, r_op};

endmodule

// File: rtl/pe_tile_param.sv
// pe_tile_param
// One routing tile of the CGRA fabric: two connect boxes feed a multi-op PE,
// and a switch box routes inter-tile tracks plus the PE result.
// Optional feature macro: PE_TILE_READBACK_EN (configuration readback).
// Parameters: TRACKS tracks per side, WIDTH bits per track, OUT_SIDES mask of
//   sides whose outputs are driven (undriven sides output 0).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   config_valid      configuration write strobe
//   config_addr[31:0] [15:0] tile id, [31:16] block code
//   config_data[31:0] write payload
//   tile_id[15:0]     this tile's id
//   in_wires          side s, track t at bit ((s*TRACKS)+t)*WIDTH
//   out_wires         same packing as in_wires
//   config_rdata      readback data (0 unless PE_TILE_READBACK_EN)
//   config_rvalid     readback valid (0 unless PE_TILE_READBACK_EN)
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int         TRACKS    = 4,
  parameter int         WIDTH     = 1,
  parameter logic [3:0] OUT_SIDES = 4'b1111
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      config_valid,
  input  logic [31:0]               config_addr,
  input  logic [31:0]               config_data,
  input  logic [15:0]               tile_id,
  input  logic [4*TRACKS*WIDTH-1:0] in_wires,
  output logic [4*TRACKS*WIDTH-1:0] out_wires,
  output logic [31:0]               config_rdata,
  output logic                      config_rvalid
);

  localparam int SB_WORDS = sbWords(TRACKS);
  localparam int CB_SEL_W = $clog2(2 * TRACKS);

  logic [SB_WORDS*32-1:0] r_sbCfg;
  logic [CB_SEL_W-1:0]    r_cb0Sel;
  logic [CB_SEL_W-1:0]    r_cb1Sel;

  logic                      w_match;
  logic                      w_write;
  logic                      w_clbWrite;
  logic [15:0]               w_code;
  logic [WIDTH-1:0]          w_op0;
  logic [WIDTH-1:0]          w_op1;
  logic [WIDTH-1:0]          w_peResult;
  logic [WIDTH-1:0]          w_peReg;
  logic [3:0]                w_clbCfg;
  logic [TRACKS*WIDTH-1:0]   w_fbSide0;
  logic [TRACKS*WIDTH-1:0]   w_fbSide1;

  assign w_match    = (config_addr[15:0] == tile_id);
  assign w_write    = config_valid && w_match;
  assign w_code     = config_addr[31:16];
  assign w_clbWrite = w_write && (w_code == CLB_CODE);

  // Connect-box and switch-box configuration. Every matching strobe cycle is
  // a write; codes that name no register simply fall through all the ifs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sbCfg  <= '0;
      r_cb0Sel <= '0;
      r_cb1Sel <= '0;
    end else if (w_write) begin
      if (w_code == CB0_CODE) r_cb0Sel <= config_data[CB_SEL_W-1:0];
      if (w_code == CB1_CODE) r_cb1Sel <= config_data[CB_SEL_W-1:0];
      for (int k = 0; k < SB_WORDS; k++) begin
        if (w_code == SB_BASE_CODE + 16'(k)) r_sbCfg[k*32 +: 32] <= config_data;
      end
    end
  end

  // Switch box. Each output also produces a copy for the connect boxes in
  // which a PE-selected track carries the PE register rather than the live
  // PE result. The only legal way for a CB to see a PE-fed out_wire is with
  // the PE registered, where both values are identical; using the register
  // keeps the netlist free of a structural combinational loop.
  for (genvar gs = 0; gs < 4; gs++) begin : g_side
    for (genvar gt = 0; gt < TRACKS; gt++) begin : g_track
      localparam int IDX = gs * TRACKS + gt;
      sbSel_t           w_sel;
      logic [WIDTH-1:0] w_track;

      assign w_sel = sbSel_t'(r_sbCfg[2*IDX +: 2]);

      always_comb begin
        w_track = '0;
        case (w_sel)
          SB_OPPOSITE: w_track = in_wires[(((gs+2)%4)*TRACKS+gt)*WIDTH +: WIDTH];
          SB_NEXT:     w_track = in_wires[(((gs+1)%4)*TRACKS+gt)*WIDTH +: WIDTH];
          SB_PREV:     w_track = in_wires[(((gs+3)%4)*TRACKS+gt)*WIDTH +: WIDTH];
          default:     w_track = '0;
        endcase
      end

      assign out_wires[IDX*WIDTH +: WIDTH] =
        !OUT_SIDES[gs]     ? '0 :
        (w_sel == SB_PE)   ? w_peResult : w_track;

      if (gs == 0) begin : g_fb0
        assign w_fbSide0[gt*WIDTH +: WIDTH] =
          !OUT_SIDES[gs] ? '0 : (w_sel == SB_PE) ? w_peReg : w_track;
      end else if (gs == 1) begin : g_fb1
        assign w_fbSide1[gt*WIDTH +: WIDTH] =
          !OUT_SIDES[gs] ? '0 : (w_sel == SB_PE) ? w_peReg : w_track;
      end
    end
  end

  // Connect boxes: selector values below TRACKS pick an incoming track of
  // the CB's side, the next TRACKS values pick that side's outgoing track.
  // Out-of-range selectors (non power-of-two track counts) yield 0.
  always_comb begin
    w_op0 = '0;
    w_op1 = '0;
    for (int v = 0; v < TRACKS; v++) begin
      if (r_cb0Sel == CB_SEL_W'(v))          w_op0 = in_wires[v*WIDTH +: WIDTH];
      if (r_cb0Sel == CB_SEL_W'(v + TRACKS)) w_op0 = w_fbSide0[v*WIDTH +: WIDTH];
      if (r_cb1Sel == CB_SEL_W'(v))          w_op1 = in_wires[(TRACKS+v)*WIDTH +: WIDTH];
      if (r_cb1Sel == CB_SEL_W'(v + TRACKS)) w_op1 = w_fbSide1[v*WIDTH +: WIDTH];
    end
  end

  pe_tile_clb #(
    .WIDTH(WIDTH)
  ) u_clb (
    .clk        (clk),
    .reset      (reset),
    .i_cfgWrite (w_clbWrite),
    .i_cfgData  (config_data[3:0]),
    .i_op0      (w_op0),
    .i_op1      (w_op1),
    .o_result   (w_peResult),
    .o_peReg    (w_peReg),
    .o_cfg      (w_clbCfg)
  );

`ifdef PE_TILE_READBACK_EN
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [31:0] w_rdMux;
  logic        w_read;

  // An addressed cycle without the strobe is a read of the coded register.
  assign w_read = !config_valid && w_match;

  // Readback source select, zero-extended; unknown codes read as 0.
  always_comb begin
    w_rdMux = '0;
    if (w_code == CLB_CODE) w_rdMux = {28'd0, w_clbCfg};
    if (w_code == CB0_CODE) w_rdMux = 32'(r_cb0Sel);
    if (w_code == CB1_CODE) w_rdMux = 32'(r_cb1Sel);
    for (int k = 0; k < SB_WORDS; k++) begin
      if (w_code == SB_BASE_CODE + 16'(k)) w_rdMux = r_sbCfg[k*32 +: 32];
    end
  end

  // Read response: valid pulses for exactly the cycle after the request,
  // data holds until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_read;
      if (w_read) r_rdata <= w_rdMux;
    end
  end

  assign config_rdata  = r_rdata;
  assign config_rvalid = r_rvalid;
`else
  logic w_unusedClbCfg;

  assign w_unusedClbCfg = ^w_clbCfg;
  assign config_rdata   = '0;
  assign config_rvalid  = 1'b0;
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
// tb_pe_tile_param
// Self-checking bench for pe_tile_param with TRACKS=4, WIDTH=8. Two tiles
// share every input: dutA drives all sides, dutB is a left-edge tile
// (OUT_SIDES=4'b1011). Expected outputs come from a small routing/ALU model
// and are queued when stimulus is applied, then popped at sampling time.
module tb_pe_tile_param;
  import pe_tile_pkg::*;

  localparam logic [15:0] TILE  = 16'h0012;
  localparam logic [15:0] OTHER = 16'h0034;
`ifdef PE_TILE_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  typedef struct {
    string        name;
    logic [127:0] exp;
  } expEntry_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         config_valid = 1'b0;
  logic [31:0]  config_addr = '0;
  logic [31:0]  config_data = '0;
  logic [15:0]  tileId = TILE;
  logic [127:0] inW = '0;
  logic [127:0] outA;
  logic [127:0] outB;
  logic [31:0]  rdataA;
  logic [31:0]  rdataB;
  logic         rvalidA;
  logic         rvalidB;

  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  sbModel = '0;
  expEntry_t    sbQ[$];

  always #5 clk = ~clk;

  pe_tile_param #(.TRACKS(4), .WIDTH(8), .OUT_SIDES(4'b1111)) dutA (
    .clk(clk), .reset(reset), .config_valid(config_valid),
    .config_addr(config_addr), .config_data(config_data), .tile_id(tileId),
    .in_wires(inW), .out_wires(outA),
    .config_rdata(rdataA), .config_rvalid(rvalidA)
  );

  pe_tile_param #(.TRACKS(4), .WIDTH(8), .OUT_SIDES(4'b1011)) dutB (
    .clk(clk), .reset(reset), .config_valid(config_valid),
    .config_addr(config_addr), .config_data(config_data), .tile_id(tileId),
    .in_wires(inW), .out_wires(outB),
    .config_rdata(rdataB), .config_rvalid(rvalidB)
  );

  // Routing model: selector 0 opposite side, 1 side+1, 2 side+3, 3 PE.
  function automatic logic [127:0] modelOut(input logic [127:0] iw, input logic [31:0] sb,
                                            input logic [7:0] pe, input logic [3:0] sides);
    logic [127:0] r;
    logic [1:0]   sel;
    logic [7:0]   v;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 4; t++) begin
        sel = sb[2*(s*4+t) +: 2];
        case (sel)
          2'd0:    v = iw[(((s+2)%4)*4+t)*8 +: 8];
          2'd1:    v = iw[(((s+1)%4)*4+t)*8 +: 8];
          2'd2:    v = iw[(((s+3)%4)*4+t)*8 +: 8];
          default: v = pe;
        endcase
        if (sides[s]) r[(s*4+t)*8 +: 8] = v;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] trk(input logic [127:0] v, input int s, input int t);
    return v[(s*4+t)*8 +: 8];
  endfunction

  function automatic logic [127:0] setTrk(input logic [127:0] v, input int s, input int t,
                                          input logic [7:0] d);
    logic [127:0] r;
    r = v;
    r[(s*4+t)*8 +: 8] = d;
    return r;
  endfunction

  function automatic logic [127:0] randWires();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic expectOut(input string name, input logic [127:0] val);
    expEntry_t e;
    e.name = name;
    e.exp  = val;
    sbQ.push_back(e);
  endtask

  // One strobed write to this tile; the address is parked on a foreign id
  // afterwards so idle cycles never look like reads.
  task automatic cfgWrite(input logic [15:0] code, input logic [31:0] data);
    config_valid = 1'b1;
    config_addr  = {code, TILE};
    config_data  = data;
    @(posedge clk); #1;
    config_valid = 1'b0;
    config_addr  = {code, OTHER};
  endtask

  task automatic doRead(input logic [15:0] code, output logic vA, output logic [31:0] dA,
                        output logic [31:0] dB, output logic vAfter);
    config_valid = 1'b0;
    config_addr  = {code, TILE};
    @(posedge clk); #1;
    config_addr  = {code, OTHER};
    vA = rvalidA;
    dA = rdataA;
    dB = rdataB;
    @(posedge clk); #1;
    vAfter = rvalidA;
  endtask

  task automatic test_reset();
    expEntry_t e;
    logic v, va;
    logic [31:0] d, db;
    #1 reset = 1'b1;
    inW = setTrk(randWires(), 0, 2, 8'hA5);
    sbModel = '0;
    #1;
    expectOut("reset_route", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    vectors++;
    if (trk(outA, 2, 2) !== 8'hA5) begin
      miscompares++; $display("[TB] FAIL reset_s2t2: got %h expected a5", trk(outA, 2, 2));
    end
    vectors++;
    if (rvalidA !== 1'b0 || rdataA !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_rd: got %b/%h expected 0/0", rvalidA, rdataA);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int c = 4; c <= 6; c++) begin
      doRead(16'(c), v, d, db, va);
      vectors++;
      if (v !== RB_EN || d !== 32'd0) begin
        miscompares++; $display("[TB] FAIL reset_read code %0d: got %b/%h expected %b/0", c, v, d, RB_EN);
      end
    end
  endtask

  task automatic test_foreign_and_disabled();
    expEntry_t e;
    // Foreign tile id, matching id without strobe, unknown codes: all ignored.
    config_valid = 1'b1; config_addr = {SB_BASE_CODE, OTHER}; config_data = 32'h5555_5555;
    @(posedge clk); #1;
    config_valid = 1'b0; config_addr = {SB_BASE_CODE, TILE};
    @(posedge clk); #1;
    config_valid = 1'b1; config_addr = {16'd3, TILE}; config_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    config_addr = {16'd8, TILE};
    @(posedge clk); #1;
    config_valid = 1'b0; config_addr = {16'd0, OTHER};
    for (int i = 0; i < 3; i++) begin
      inW = randWires(); #1;
      expectOut("foreign_A", modelOut(inW, sbModel, 8'h00, 4'b1111));
      expectOut("edge_B", modelOut(inW, sbModel, 8'h00, 4'b1011));
      e = sbQ.pop_front(); vectors++;
      if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
      e = sbQ.pop_front(); vectors++;
      if (outB !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outB, e.exp); end
    end
    cfgWrite(SB_BASE_CODE, 32'h5555_5555);
    sbModel = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      inW = randWires(); #1;
      expectOut("turn_B", modelOut(inW, sbModel, 8'h00, 4'b1011));
      e = sbQ.pop_front(); vectors++;
      if (outB !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outB, e.exp); end
      vectors++;
      if (outB[95:64] !== 32'd0) begin
        miscompares++; $display("[TB] FAIL side2_off: got %h expected 0", outB[95:64]);
      end
    end
    cfgWrite(SB_BASE_CODE, 32'h0);
    sbModel = 32'h0;
  endtask

  task automatic test_turn_and_pe();
    expEntry_t e;
    cfgWrite(SB_BASE_CODE, 32'h0000_0100);
    sbModel = 32'h0000_0100;
    inW = randWires(); #1;
    expectOut("turn_s1t0", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    vectors++;
    if (trk(outA, 1, 0) !== trk(inW, 2, 0)) begin
      miscompares++; $display("[TB] FAIL turn_follow: got %h expected %h", trk(outA, 1, 0), trk(inW, 2, 0));
    end
    cfgWrite(CLB_CODE, 32'h2);
    cfgWrite(SB_BASE_CODE, 32'h0000_0300);
    sbModel = 32'h0000_0300;
    inW = setTrk(setTrk(inW, 0, 0, 8'h0F), 1, 0, 8'hF0); #1;
    expectOut("pe_xor", modelOut(inW, sbModel, 8'hFF, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    inW = setTrk(setTrk(inW, 0, 0, 8'h33), 1, 0, 8'h55); #1;
    expectOut("pe_xor_live", modelOut(inW, sbModel, 8'h66, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
  endtask

  task automatic test_alu_ops();
    expEntry_t e;
    logic [7:0] a, b, r;
    for (int op = 0; op < 7; op++) begin
      cfgWrite(CLB_CODE, 32'(op));
      a = 8'($urandom); b = 8'($urandom);
      inW = setTrk(setTrk(randWires(), 0, 0, a), 1, 0, b); #1;
      case (op)
        0: r = a & b;
        1: r = a | b;
        2: r = a ^ b;
        3: r = a + b;
        4: r = a - b;
        5: r = a;
        default: r = ~a;
      endcase
      expectOut($sformatf("alu_op%0d", op), modelOut(inW, sbModel, r, 4'b1111));
      e = sbQ.pop_front(); vectors++;
      if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    end
  endtask

  task automatic test_registered_add();
    expEntry_t e;
    inW = setTrk(setTrk(randWires(), 0, 0, 8'hC8), 1, 0, 8'h64);
    cfgWrite(CLB_CODE, 32'hB);
    expectOut("radd_clear", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    expectOut("radd_result", modelOut(inW, sbModel, 8'h2C, 4'b1111));
    @(posedge clk); #1;
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    inW = setTrk(setTrk(inW, 0, 0, 8'h01), 1, 0, 8'h02); #1;
    expectOut("radd_hold", modelOut(inW, sbModel, 8'h2C, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    expectOut("radd_next", modelOut(inW, sbModel, 8'h03, 4'b1111));
    @(posedge clk); #1;
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
  endtask

  task automatic test_accumulate();
    expEntry_t e;
    logic [7:0] accSeq [5];
    accSeq = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    inW = setTrk(randWires(), 0, 0, 8'h40);
    cfgWrite(CLB_CODE, 32'h7);
    expectOut("acc_start", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    for (int i = 0; i < 5; i++) begin
      expectOut($sformatf("acc_%0d", i), modelOut(inW, sbModel, accSeq[i], 4'b1111));
      @(posedge clk); #1;
      e = sbQ.pop_front(); vectors++;
      if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    end
    cfgWrite(CLB_CODE, 32'h7);
    expectOut("acc_rewrite", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    expectOut("acc_restart", modelOut(inW, sbModel, 8'h40, 4'b1111));
    @(posedge clk); #1;
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
  endtask

  task automatic test_cb_select();
    expEntry_t e;
    cfgWrite(CLB_CODE, 32'h5);
    cfgWrite(CB0_CODE, 32'd6);
    inW = randWires(); #1;
    expectOut("cb0_outwire", modelOut(inW, sbModel, trk(inW, 2, 2), 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    cfgWrite(CB0_CODE, 32'd3);
    cfgWrite(CB1_CODE, 32'd1);
    cfgWrite(CLB_CODE, 32'h1);
    inW = randWires(); #1;
    expectOut("cb_inwire_or", modelOut(inW, sbModel, trk(inW, 0, 3) | trk(inW, 1, 1), 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    cfgWrite(CB1_CODE, 32'd5);
    inW = randWires(); #1;
    expectOut("cb1_outwire", modelOut(inW, sbModel, trk(inW, 0, 3) | trk(inW, 3, 1), 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    cfgWrite(CB0_CODE, 32'd0);
  endtask

  task automatic test_back_to_back();
    expEntry_t e;
    logic v, va;
    logic [31:0] d, db;
    inW = randWires();
    config_valid = 1'b1; config_addr = {SB_BASE_CODE, TILE}; config_data = 32'h0000_0100;
    @(posedge clk); #1;
    expectOut("b2b_first", modelOut(inW, 32'h0000_0100, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    config_data = 32'h0000_0200;
    @(posedge clk); #1;
    config_valid = 1'b0; config_addr = {16'd0, OTHER};
    sbModel = 32'h0000_0200;
    expectOut("b2b_second", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    doRead(CB1_CODE, v, d, db, va);
    vectors++;
    if (v !== RB_EN || d !== (RB_EN ? 32'd5 : 32'd0) || db !== d) begin
      miscompares++; $display("[TB] FAIL read_cb1: got %b/%h/%h expected %b/%h", v, d, db, RB_EN, RB_EN ? 32'd5 : 32'd0);
    end
    vectors++;
    if (va !== 1'b0) begin miscompares++; $display("[TB] FAIL rvalid_pulse: got %b expected 0", va); end
    doRead(SB_BASE_CODE, v, d, db, va);
    vectors++;
    if (v !== RB_EN || d !== (RB_EN ? 32'h200 : 32'd0)) begin
      miscompares++; $display("[TB] FAIL read_sb0: got %b/%h expected %b/%h", v, d, RB_EN, RB_EN ? 32'h200 : 32'd0);
    end
    doRead(CLB_CODE, v, d, db, va);
    vectors++;
    if (v !== RB_EN || d !== (RB_EN ? 32'h1 : 32'd0)) begin
      miscompares++; $display("[TB] FAIL read_clb: got %b/%h expected %b/%h", v, d, RB_EN, RB_EN ? 32'h1 : 32'd0);
    end
    doRead(16'd3, v, d, db, va);
    vectors++;
    if (v !== RB_EN || d !== 32'd0) begin
      miscompares++; $display("[TB] FAIL read_unknown: got %b/%h expected %b/0", v, d, RB_EN);
    end
  endtask

  task automatic test_reset_mid_acc();
    expEntry_t e;
    logic v, va;
    logic [31:0] d, db;
    cfgWrite(SB_BASE_CODE, 32'h0000_0300);
    sbModel = 32'h0000_0300;
    inW = setTrk(setTrk(randWires(), 0, 0, 8'h40), 3, 0, 8'h00);
    cfgWrite(CLB_CODE, 32'h7);
    expectOut("mid_acc", modelOut(inW, sbModel, 8'h80, 4'b1111));
    @(posedge clk); @(posedge clk); #1;
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    @(negedge clk); reset = 1'b1;
    sbModel = 32'h0;
    #1;
    expectOut("mid_reset", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    vectors++;
    if (trk(outA, 1, 0) !== 8'h00) begin
      miscompares++; $display("[TB] FAIL mid_reset_s1t0: got %h expected 00", trk(outA, 1, 0));
    end
    config_valid = 1'b1; config_addr = {SB_BASE_CODE, TILE}; config_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; config_valid = 1'b0; config_addr = {16'd0, OTHER};
    #1;
    expectOut("lost_write", modelOut(inW, sbModel, 8'h00, 4'b1111));
    e = sbQ.pop_front(); vectors++;
    if (outA !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h expected %h", e.name, outA, e.exp); end
    doRead(CLB_CODE, v, d, db, va);
    vectors++;
    if (v !== RB_EN || d !== 32'd0) begin
      miscompares++; $display("[TB] FAIL read_clb_after_reset: got %b/%h expected %b/0", v, d, RB_EN);
    end
  endtask

  initial begin
    $display("[TB] pe_tile_param bench start (readback=%0d)", RB_EN);
    test_reset();
    test_foreign_and_disabled();
    test_turn_and_pe();
    test_alu_ops();
    test_registered_add();
    test_accumulate();
    test_cb_select();
    test_back_to_back();
    test_reset_mid_acc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
